// File: rtl/box_pkg.sv
// ---------------------------------------------------------------------------
// box_pkg
// Purpose : shared widths, screen dimensions and direction encoding for the
//           bouncing-box datapath that drives the 160x120 vga_adapter.
// Contents: X_W / Y_W / COLOUR_W pixel field widths, SCREEN_X / SCREEN_Y
//           screen size, dir_t (DIR_POS moves right/down, DIR_NEG left/up).
// ---------------------------------------------------------------------------
package box_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam int SCREEN_X = 160;
    localparam int SCREEN_Y = 120;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

endpackage

// File: rtl/box_sweep_counter.sv
// ---------------------------------------------------------------------------
// box_sweep_counter
// Purpose : walks the SIZE x SIZE pixel area of the box in row-major order,
//           x fastest, and flags the last pixel of the sweep.
// Ports   : clk  - system clock
//           rst  - asynchronous reset, active high
//           en   - sweep enable; low clears the count so a new sweep
//                  always starts from the top-left pixel
//           cx   - column offset inside the box (cnt % SIZE)
//           cy   - row offset inside the box (cnt / SIZE)
//           last - high while enabled on the final pixel of the sweep
// ---------------------------------------------------------------------------
module box_sweep_counter #(
    parameter int SIZE = 4,
    parameter int CXW  = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic [CXW-1:0] cx,
    output logic [CXW-1:0] cy,
    output logic           last
);

    localparam int TOTAL = SIZE * SIZE;
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int LAST  = TOTAL - 1;

    logic [CNT_W-1:0] cnt;

    // Count wraps to zero after the last pixel so back-to-back sweeps
    // under a continuously held enable restart cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign cx   = CXW'(cnt % CNT_W'(SIZE));
    assign cy   = CXW'(cnt / CNT_W'(SIZE));

    // Reset must hold finish low even if the controller still drives enable.
    assign last = en & ~rst & (cnt == CNT_W'(LAST));

endmodule

// File: rtl/box_datapath.sv
// ---------------------------------------------------------------------------
// box_datapath
// Purpose : datapath for the bouncing-box VGA demo. Holds the box position
//           and direction, bounces it off the screen edges on each move
//           pulse, and sweeps the box area to feed the vga_adapter.
// Ports   : clk       - system clock (50 MHz)
//           resetn    - asynchronous reset, ACTIVE HIGH despite the name
//           init      - load start position and +,+ direction
//           move      - one-cycle pulse, advance STEP per axis with bounce
//           wren      - sweep enable, held for a whole erase/draw pass
//           drawColor - colour of the pixels in the current sweep
//           finish    - combinational, high while the last pixel is issued
//           x, y      - registered pixel coordinate
//           colour    - registered pixel colour
//           plot      - registered write strobe
// Config  : define BOX_OUTLINE_EN to plot only the border pixels of the box;
//           interior cycles are still counted so finish timing is unchanged.
// ---------------------------------------------------------------------------
module box_datapath
    import box_pkg::*;
#(
    parameter int SIZE    = 4,
    parameter int X_MAX   = SCREEN_X,
    parameter int Y_MAX   = SCREEN_Y,
    parameter int X_START = 0,
    parameter int Y_START = 0,
    parameter int STEP    = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                init,
    input  logic                move,
    input  logic                wren,
    input  logic [COLOUR_W-1:0] drawColor,
    output logic                finish,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot
);

    localparam int CXW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [X_W-1:0] px, px_next;
    logic [Y_W-1:0] py, py_next;
    dir_t           dir_x, dir_x_next;
    dir_t           dir_y, dir_y_next;
    logic [CXW-1:0] cx, cy;
    logic           last;
    logic           on_pixel;

    box_sweep_counter #(
        .SIZE (SIZE),
        .CXW  (CXW)
    ) u_sweep (
        .clk  (clk),
        .rst  (resetn),
        .en   (wren),
        .cx   (cx),
        .cy   (cy),
        .last (last)
    );

    assign finish = last;

`ifdef BOX_OUTLINE_EN
    assign on_pixel = (cx == '0) | (cx == CXW'(SIZE - 1)) |
                      (cy == '0) | (cy == CXW'(SIZE - 1));
`else
    assign on_pixel = 1'b1;
`endif

    // Next position: init wins over move. A move in the + direction that
    // would push the far edge of the box off screen reverses and steps back
    // instead; a move in the - direction that would go below 0 does the same.
    always_comb begin
        px_next    = px;
        py_next    = py;
        dir_x_next = dir_x;
        dir_y_next = dir_y;
        if (init) begin
            px_next    = X_W'(X_START);
            py_next    = Y_W'(Y_START);
            dir_x_next = DIR_POS;
            dir_y_next = DIR_POS;
        end else if (move) begin
            if (dir_x == DIR_POS) begin
                if (int'(px) + SIZE - 1 + STEP > X_MAX - 1) begin
                    dir_x_next = DIR_NEG;
                    px_next    = px - X_W'(STEP);
                end else begin
                    px_next    = px + X_W'(STEP);
                end
            end else begin
                if (int'(px) < STEP) begin
                    dir_x_next = DIR_POS;
                    px_next    = px + X_W'(STEP);
                end else begin
                    px_next    = px - X_W'(STEP);
                end
            end
            if (dir_y == DIR_POS) begin
                if (int'(py) + SIZE - 1 + STEP > Y_MAX - 1) begin
                    dir_y_next = DIR_NEG;
                    py_next    = py - Y_W'(STEP);
                end else begin
                    py_next    = py + Y_W'(STEP);
                end
            end else begin
                if (int'(py) < STEP) begin
                    dir_y_next = DIR_POS;
                    py_next    = py + Y_W'(STEP);
                end else begin
                    py_next    = py - Y_W'(STEP);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            px    <= X_W'(X_START);
            py    <= Y_W'(Y_START);
            dir_x <= DIR_POS;
            dir_y <= DIR_POS;
        end else begin
            px    <= px_next;
            py    <= py_next;
            dir_x <= dir_x_next;
            dir_y <= dir_y_next;
        end
    end

    // Pixel outputs use the position as it stands this cycle; x/y/colour
    // hold their last value when no sweep is running.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
        end else if (wren) begin
            plot   <= on_pixel;
            x      <= px + X_W'(cx);
            y      <= py + Y_W'(cy);
            colour <= drawColor;
        end else begin
            plot   <= 1'b0;
        end
    end

endmodule
